// File: rtl/vend_coin_feeder_if.sv
// Request/coin bus bundle between a payer (vend_coin_feeder) and its requester and vending machine.
// VEND_FEEDER_ABORT_EN adds the abort request line.
interface vend_coin_feeder_if #(
  parameter int unsigned AMT_W = 4
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             prefer2;
  logic             pr;
  logic             ch;
`ifdef VEND_FEEDER_ABORT_EN
  logic             abort;
`endif
  logic [1:0]       coin;
  logic             busy;
  logic             done;
  logic             got_product;
  logic             got_change;
  logic             timeout_err;
  logic [AMT_W-1:0] leftover;

  modport master (
`ifdef VEND_FEEDER_ABORT_EN
    input  abort,
`endif
    input  start, amount, prefer2, pr, ch,
    output coin, busy, done, got_product, got_change, timeout_err, leftover
  );

  modport slave (
`ifdef VEND_FEEDER_ABORT_EN
    output abort,
`endif
    output start, amount, prefer2, pr, ch,
    input  coin, busy, done, got_product, got_change, timeout_err, leftover
  );
endinterface

// File: rtl/vend_coin_feeder.sv
// Payer-side coin feeder: pays a requested amount as gapped coin pulses and reports the outcome.
// Optional macro VEND_FEEDER_ABORT_EN enables the abort input.
module vend_coin_feeder #(
  parameter int unsigned AMT_W        = 4,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned RESP_TIMEOUT = 20,
  parameter int unsigned TMR_W        = 5
) (
  input logic               clk,
  input logic               rstn,
  vend_coin_feeder_if.master bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StGap, StWait, StDone} state_e;

  localparam logic [TMR_W-1:0] GapLast  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] WaitLast = TMR_W'(RESP_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             pref_q, pref_d;
  logic [1:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             got_product_q, got_product_d;
  logic             got_change_q, got_change_d;
  logic             timeout_err_q, timeout_err_d;
  logic [AMT_W-1:0] leftover_q, leftover_d;
  logic             abort_req;
  logic             active;

`ifdef VEND_FEEDER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [1:0] pick_coin(input logic pref, input logic [AMT_W-1:0] r);
    return (pref && (r > AMT_W'(1))) ? 2'd2 : 2'd1;
  endfunction

  assign active = (state_q == StDrive) || (state_q == StGap) || (state_q == StWait);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rem_d         = rem_q;
    pref_d        = pref_q;
    coin_d        = 2'd0;
    got_product_d = got_product_q;
    got_change_d  = got_change_q;
    timeout_err_d = timeout_err_q;
    leftover_d    = leftover_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          pref_d        = bus.prefer2;
          rem_d         = bus.amount;
          got_product_d = 1'b0;
          got_change_d  = 1'b0;
          timeout_err_d = 1'b0;
          leftover_d    = '0;
          if (bus.amount == '0) begin
            state_d = StDone;
          end else begin
            // coin_q is registered, so the coin is chosen here to appear in the DRIVE cycle
            coin_d  = pick_coin(bus.prefer2, bus.amount);
            rem_d   = bus.amount - AMT_W'(coin_d);
            state_d = StDrive;
          end
        end
      end
      StDrive: begin
        state_d = StGap;
        timer_d = '0;
      end
      StGap: begin
        if (timer_q == GapLast) begin
          if (rem_q != '0) begin
            coin_d  = pick_coin(pref_q, rem_q);
            rem_d   = rem_q - AMT_W'(coin_d);
            state_d = StDrive;
          end else begin
            state_d = StWait;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWait: begin
        if (timer_q == WaitLast) begin
          timeout_err_d = 1'b1;
          state_d       = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // pr beats both timeout and abort; a coin already on the bus finishes its cycle
    if (active && (bus.pr || abort_req)) begin
      got_product_d = bus.pr;
      got_change_d  = bus.pr & bus.ch;
      timeout_err_d = 1'b0;
      coin_d        = 2'd0;
      rem_d         = rem_q;
      timer_d       = '0;
      state_d       = StDone;
    end

    if (state_d == StDone) begin
      leftover_d = rem_d;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      rem_q         <= '0;
      pref_q        <= 1'b0;
      coin_q        <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      got_product_q <= 1'b0;
      got_change_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      leftover_q    <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rem_q         <= rem_d;
      pref_q        <= pref_d;
      coin_q        <= coin_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      got_product_q <= got_product_d;
      got_change_q  <= got_change_d;
      timeout_err_q <= timeout_err_d;
      leftover_q    <= leftover_d;
    end
  end

  assign bus.coin        = coin_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.got_product = got_product_q;
  assign bus.got_change  = got_change_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.leftover    = leftover_q;

endmodule
